// File: rtl/rx_chan_packer.sv
// RX channel staging: buffers ADC sample words in a FWFT FIFO and queues per-packet headers for the packet builder.
// Optional RX_PACKER_TAG_SEQ_EN: when defined, tag carries a commit sequence number; otherwise tag is 0.
module rx_chan_packer #(
  parameter int PAYLOAD_WORDS = 252,
  parameter int FIFO_AW       = 9,
  parameter int CHAN_NUM      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_strobe,
  input  logic [15:0]        sample_data,
  input  logic [31:0]        timestamp_in,
  input  logic [5:0]         rssi_in,
  output logic               have_packet,
  input  logic               header_ack,
  input  logic               chan_rd,
  output logic [15:0]        chan_data,
  output logic [8:0]         payload_length,
  output logic [31:0]        timestamp,
  output logic               overrun,
  output logic               dropped_packet,
  output logic               start_burst,
  output logic               end_burst,
  output logic               underrun,
  output logic [5:0]         rssi,
  output logic [4:0]         chan_number,
  output logic [3:0]         tag,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WCW   = $clog2(PAYLOAD_WORDS + 1);

  typedef struct packed {
    logic [8:0]  len;
    logic [31:0] ts;
    logic [5:0]  rssi;
    logic        ovr;
    logic        drop;
    logic        sb;
    logic        eb;
    logic [3:0]  tag;
  } hdr_t;

  // sample FIFO
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  // header ring
  hdr_t       hq [2];
  logic       hq_wp, hq_rp;
  logic [1:0] hq_cnt;

  logic [WCW-1:0] word_cnt;
  logic           overrun_pend, drop_pend, burst_pend, enable_q;
  logic [31:0]    open_ts;
  logic [5:0]     open_rssi;
  logic           open_sb;
  logic [3:0]     seq_cur;

  logic fifo_full, fifo_empty, hq_free, accept, pop, open_pkt, fill_commit;
  logic fall, rise, commit, hack, burst_eff;
  logic [WCW-1:0] len_words;
  hdr_t new_hdr, head;

  assign fifo_full   = (count == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty  = (count == '0);
  assign hq_free     = (hq_cnt != 2'd2);
  assign accept      = sample_strobe && enable && !fifo_full && (word_cnt != '0 || hq_free);
  assign pop         = chan_rd && !fifo_empty;
  assign open_pkt    = accept && (word_cnt == '0);
  assign fill_commit = accept && (word_cnt == WCW'(PAYLOAD_WORDS - 1));
  assign fall        = enable_q && !enable;
  assign rise        = !enable_q && enable;
  assign commit      = fill_commit || (fall && word_cnt != '0);
  assign hack        = header_ack && (hq_cnt != 2'd0);
  // a word accepted on the rising-edge cycle must already see the new burst
  assign burst_eff   = burst_pend || rise;
  assign len_words   = fill_commit ? WCW'(PAYLOAD_WORDS) : word_cnt;

`ifdef RX_PACKER_TAG_SEQ_EN
  logic [3:0] seq;
  always_ff @(posedge clk) begin
    if (reset)       seq <= 4'd0;
    else if (commit) seq <= seq + 4'd1;
  end
  assign seq_cur = seq;
`else
  assign seq_cur = 4'd0;
`endif

  always_comb begin
    new_hdr      = '0;
    new_hdr.len  = 9'(len_words) << 1;
    // single-word packets open and commit in the same cycle
    new_hdr.ts   = open_pkt ? timestamp_in : open_ts;
    new_hdr.rssi = open_pkt ? rssi_in : open_rssi;
    new_hdr.sb   = open_pkt ? burst_eff : open_sb;
    new_hdr.eb   = !fill_commit;
    new_hdr.ovr  = overrun_pend;
    new_hdr.drop = drop_pend;
    new_hdr.tag  = seq_cur;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hq_wp        <= 1'b0;
      hq_rp        <= 1'b0;
      hq_cnt       <= 2'd0;
      word_cnt     <= '0;
      overrun_pend <= 1'b0;
      drop_pend    <= 1'b0;
      burst_pend   <= 1'b1;
      enable_q     <= 1'b0;
      open_ts      <= '0;
      open_rssi    <= '0;
      open_sb      <= 1'b0;
      hq[0]        <= '0;
      hq[1]        <= '0;
    end else begin
      enable_q <= enable;
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase

      if (commit)      word_cnt <= '0;
      else if (accept) word_cnt <= word_cnt + WCW'(1);

      if (open_pkt) begin
        open_ts   <= timestamp_in;
        open_rssi <= rssi_in;
        open_sb   <= burst_eff;
      end
      burst_pend <= open_pkt ? 1'b0 : burst_eff;

      if (commit) begin
        overrun_pend <= 1'b0;
        drop_pend    <= 1'b0;
      end
      if (sample_strobe && enable && fifo_full) overrun_pend <= 1'b1;
      if (sample_strobe && enable && word_cnt == '0 && !hq_free) drop_pend <= 1'b1;

      if (commit) begin
        hq[hq_wp] <= new_hdr;
        hq_wp     <= ~hq_wp;
      end
      if (hack) hq_rp <= ~hq_rp;
      case ({commit, hack})
        2'b10:   hq_cnt <= hq_cnt + 2'd1;
        2'b01:   hq_cnt <= hq_cnt - 2'd1;
        default: hq_cnt <= hq_cnt;
      endcase
    end
  end

  assign head           = (hq_cnt != 2'd0) ? hq[hq_rp] : '0;
  assign have_packet    = (hq_cnt != 2'd0);
  assign payload_length = head.len;
  assign timestamp      = head.ts;
  assign rssi           = head.rssi;
  assign overrun        = head.ovr;
  assign dropped_packet = head.drop;
  assign start_burst    = head.sb;
  assign end_burst      = head.eb;
  assign tag            = head.tag;
  assign underrun       = 1'b0;
  assign chan_number    = 5'(CHAN_NUM);
  assign chan_data      = fifo_empty ? 16'hDEAD : mem[rd_ptr];
  assign fifo_level     = count;
endmodule

// File: tb/tb_rx_chan_packer.sv
// Directed bench for rx_chan_packer: full packets, drain, enable-drop commit, overrun, dropped packet, reset.
module tb_rx_chan_packer;
  logic        clk = 1'b0;
  logic        reset, enable, sample_strobe, header_ack, chan_rd;
  logic [15:0] sample_data, chan_data;
  logic [31:0] timestamp_in, timestamp;
  logic [5:0]  rssi_in, rssi;
  logic        have_packet, overrun, dropped_packet, start_burst, end_burst, underrun;
  logic [8:0]  payload_length;
  logic [4:0]  chan_number;
  logic [3:0]  tag;
  logic [9:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int nseq   = 0;

  rx_chan_packer dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_strobe(sample_strobe),
    .sample_data(sample_data), .timestamp_in(timestamp_in), .rssi_in(rssi_in),
    .have_packet(have_packet), .header_ack(header_ack), .chan_rd(chan_rd),
    .chan_data(chan_data), .payload_length(payload_length), .timestamp(timestamp),
    .overrun(overrun), .dropped_packet(dropped_packet), .start_burst(start_burst),
    .end_burst(end_burst), .underrun(underrun), .rssi(rssi), .chan_number(chan_number),
    .tag(tag), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_tag(input int n);
`ifdef RX_PACKER_TAG_SEQ_EN
    return 32'(n % 16);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic send(input int n, input logic [15:0] base, input logic [31:0] ts,
                      input bit auto_ack, input bit rd);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      sample_data   = base + 16'(i);
      timestamp_in  = ts + 32'(i);
      header_ack    = auto_ack && have_packet;
      chan_rd       = rd;
      step();
    end
    sample_strobe = 1'b0;
    header_ack    = 1'b0;
    chan_rd       = 1'b0;
  endtask

  task automatic ack();
    header_ack = 1'b1;
    step();
    header_ack = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 700 && fifo_level != 10'd0; i++) begin
      chan_rd = 1'b1;
      step();
    end
    chan_rd = 1'b0;
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_strobe = 1'b0; header_ack = 1'b0; chan_rd = 1'b0;
    sample_data = '0; timestamp_in = '0; rssi_in = 6'h2A;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_have", 32'(have_packet), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_data", 32'(chan_data), 32'hDEAD);
    chk("rst_len", 32'(payload_length), 32'd0);
    chk("rst_ts", timestamp, 32'd0);
    chk("rst_sb", 32'(start_burst), 32'd0);
    chk("underrun", 32'(underrun), 32'd0);
    chk("chan_num", 32'(chan_number), 32'd0);

    // full packet
    enable = 1'b1;
    step();
    send(1, 16'h1000, 32'h100, 0, 0);
    chk("lat1_data", 32'(chan_data), 32'h1000);
    chk("lat1_level", 32'(fifo_level), 32'd1);
    rssi_in = 6'h11;
    send(251, 16'h1001, 32'h101, 0, 0);
    chk("p1_have", 32'(have_packet), 32'd1);
    chk("p1_len", 32'(payload_length), 32'd504);
    chk("p1_ts", timestamp, 32'h100);
    chk("p1_rssi", 32'(rssi), 32'h2A);
    chk("p1_sb", 32'(start_burst), 32'd1);
    chk("p1_eb", 32'(end_burst), 32'd0);
    chk("p1_ovr", 32'(overrun), 32'd0);
    chk("p1_tag", 32'(tag), exp_tag(nseq)); nseq++;
    chk("p1_level", 32'(fifo_level), 32'd252);

    // builder drain
    step(); step(); step(); step();
    chk("p1_hold_len", 32'(payload_length), 32'd504);
    ack();
    chk("p1_acked", 32'(have_packet), 32'd0);
    for (int i = 0; i < 252; i++) begin
      chk("p1_data", 32'(chan_data), 32'(16'h1000 + 16'(i)));
      chan_rd = 1'b1;
      step();
    end
    chan_rd = 1'b0;
    chk("p1_empty_level", 32'(fifo_level), 32'd0);
    chk("p1_empty_data", 32'(chan_data), 32'hDEAD);
    header_ack = 1'b1; chan_rd = 1'b1;
    step();
    header_ack = 1'b0; chan_rd = 1'b0;
    chk("empty_rd_level", 32'(fifo_level), 32'd0);
    chk("empty_ack_have", 32'(have_packet), 32'd0);

    // enable drop after 10 words
    send(10, 16'h2000, 32'h200, 0, 0);
    enable = 1'b0;
    step();
    chk("p2_have", 32'(have_packet), 32'd1);
    chk("p2_len", 32'(payload_length), 32'd20);
    chk("p2_eb", 32'(end_burst), 32'd1);
    chk("p2_sb", 32'(start_burst), 32'd0);
    chk("p2_ts", timestamp, 32'h200);
    chk("p2_tag", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    chk("p2_data0", 32'(chan_data), 32'h2000);
    drain_all();
    enable = 1'b1;
    send(5, 16'h2100, 32'h300, 0, 0);
    enable = 1'b0;
    step();
    chk("p3_sb", 32'(start_burst), 32'd1);
    chk("p3_eb", 32'(end_burst), 32'd1);
    chk("p3_len", 32'(payload_length), 32'd10);
    chk("p3_tag", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    drain_all();

    // FIFO overrun: headers acked, FIFO never read
    enable = 1'b1;
    send(512, 16'h3000, 32'h400, 1, 0);
    nseq += 2;
    chk("ovr_full_level", 32'(fifo_level), 32'd512);
    chk("ovr_have0", 32'(have_packet), 32'd0);
    send(3, 16'h3FF0, 32'h800, 0, 0);
    chk("ovr_level_hold", 32'(fifo_level), 32'd512);
    enable = 1'b0;
    step();
    chk("ovr_len", 32'(payload_length), 32'd16);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_eb", 32'(end_burst), 32'd1);
    chk("ovr_tag", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    chk("ovr_data0", 32'(chan_data), 32'h3000);
    drain_all();
    enable = 1'b1;
    send(4, 16'h3100, 32'h900, 0, 0);
    enable = 1'b0;
    step();
    chk("ovr_next_flag", 32'(overrun), 32'd0);
    chk("ovr_next_len", 32'(payload_length), 32'd8);
    chk("ovr_next_tag", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    drain_all();

    // header queue full -> dropped packet
    enable = 1'b1;
    send(504, 16'h4000, 32'hA00, 0, 0);
    chk("drp_level", 32'(fifo_level), 32'd504);
    send(1, 16'h4FFF, 32'hB00, 0, 0);
    chk("drp_level_hold", 32'(fifo_level), 32'd504);
    chk("drp_head_len", 32'(payload_length), 32'd504);
    chk("drp_tag_a", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    chk("drp_have_b", 32'(have_packet), 32'd1);
    chk("drp_tag_b", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    chk("drp_have_0", 32'(have_packet), 32'd0);
    send(3, 16'h4100, 32'hC00, 0, 0);
    enable = 1'b0;
    step();
    chk("drp_flag", 32'(dropped_packet), 32'd1);
    chk("drp_len", 32'(payload_length), 32'd6);
    chk("drp_tag_c", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    enable = 1'b1;
    send(2, 16'h4200, 32'hD00, 0, 0);
    enable = 1'b0;
    step();
    chk("drp_next_flag", 32'(dropped_packet), 32'd0);
    chk("drp_next_tag", 32'(tag), exp_tag(nseq)); nseq++;
    ack();
    drain_all();

    // reset mid-packet, then simultaneous push/pop
    enable = 1'b1;
    send(100, 16'h5000, 32'hE00, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_have", 32'(have_packet), 32'd0);
    chk("mid_rst_data", 32'(chan_data), 32'hDEAD);
    send(10, 16'h6000, 32'h500, 0, 0);
    send(10, 16'h600A, 32'h50A, 0, 1);
    chk("pushpop_level", 32'(fifo_level), 32'd10);
    chk("pushpop_data", 32'(chan_data), 32'h600A);
    send(232, 16'h6014, 32'h514, 0, 0);
    chk("rst_pkt_have", 32'(have_packet), 32'd1);
    chk("rst_pkt_sb", 32'(start_burst), 32'd1);
    chk("rst_pkt_ts", timestamp, 32'h500);
    chk("rst_pkt_len", 32'(payload_length), 32'd504);
    chk("rst_pkt_tag", 32'(tag), exp_tag(0));
    chk("rst_pkt_level", 32'(fifo_level), 32'd242);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
